riscv_muldiv_unit: RTL

//   Iterative RV32M/RV64M multiply/divide unit; companion to the single-cycle ALU for the M extension.

---
 rtl/riscv_muldiv_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_muldiv_unit.sv
// -----------------------------------------------------------------------------
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. It sits beside the single-cycle
//   ALU and handles the M-extension ops that need several cycles to finish.
//
//   Handshakes: each side (in_*, out_*) is a plain valid/ready pair. A transfer
//   happens on a rising clk edge where valid and ready are both high. A producer
//   keeps its payload stable from the first valid cycle until that transfer.
//   in_ready is high only in IDLE. out_valid is high only in DONE, and it stays
//   high until out_ready, flush or rst.
//
//   Ports
//     clk, rst            clock (rising edge), synchronous active-high reset
//     flush               drop the in-flight op or the pending result
//     in_valid/in_ready   op request handshake
//     in_op               funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                                 4 DIV 5 DIVU 6 REM 7 REMU
//     in_a, in_b, in_tag  rs1, rs2 and the destination tag
//     out_valid/out_ready result handshake
//     out_result, out_tag registered result and the tag of its op
//     busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module riscv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int N  = XLEN / MUL_STEP;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // Multiplicand for MUL ops, divisor magnitude for DIV ops.
    logic [XLEN-1:0]     opb_q, opb_d;
    // Dividend shifting out at the top while quotient bits shift in at the bottom.
    logic [XLEN-1:0]     quo_q, quo_d;
    // Upper half is the running sum, lower half is the multiplier shifting out.
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [TAG_W-1:0]    tag_q, tag_d;

    // ---------------------------------------------------------------- decode
    logic            a_signed, b_signed, a_s, b_s, is_div, b_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        is_div   = in_op[2];
        a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        a_s      = a_signed & in_a[XLEN-1];
        b_s      = b_signed & in_b[XLEN-1];
        mag_a    = a_s ? -in_a : in_a;
        mag_b    = b_s ? -in_b : in_b;
        b_zero   = (in_b == '0);
        div_ovf  = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                   (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == {XLEN{1'b1}});
        // in_op[1] separates the remainder flavours from the quotient flavours.
        special_res = '0;
        if (b_zero) begin
            special_res = in_op[1] ? in_a : {XLEN{1'b1}};
        end else if (div_ovf) begin
            special_res = in_op[1] ? '0 : in_a;
        end
    end

    // -------------------------------------------------------- multiply step
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_next, mul_fix;
    logic [XLEN-1:0]          mul_res;

    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]};
        for (int i = 0; i < MUL_STEP; i++) begin
            if (prod_q[i]) begin
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, opb_q} << i);
            end
        end
        mul_next = {mul_sum, prod_q[XLEN-1:MUL_STEP]};
        mul_fix  = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 3'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

    // ---------------------------------------------------------- divide step
    logic [XLEN:0]   div_shift, rem_next;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;
    logic [XLEN-1:0] quo_next, q_fix, r_fix, div_res;

    always_comb begin
        div_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_diff[XLEN+1];
        rem_next  = div_ok ? div_diff[XLEN:0] : div_shift;
        quo_next  = {quo_q[XLEN-2:0], div_ok};
        // neg_q is the quotient sign for DIV and the sign of a for REM.
        q_fix     = neg_q ? -quo_next : quo_next;
        r_fix     = neg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
        div_res   = op_q[1] ? r_fix : q_fix;
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        opb_d   = opb_q;
        quo_d   = quo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        res_d   = res_q;
        tag_d   = tag_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d  = in_op;
                        tag_d = in_tag;
                        neg_d = (in_op == 3'd6) ? a_s : (a_s ^ b_s);
                        cnt_d = '0;
                        if (!is_div) begin
                            state_d = S_MUL;
                            opb_d   = mag_a;
                            prod_d  = {{XLEN{1'b0}}, mag_b};
                        end else if (b_zero || div_ovf) begin
                            state_d = S_DONE;
                            res_d   = special_res;
                        end else begin
                            state_d = S_DIV;
                            opb_d   = mag_b;
                            quo_d   = mag_a;
                            rem_d   = '0;
                        end
                    end
                end
                S_MUL: begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_DONE;
                        res_d   = mul_res;
                        cnt_d   = '0;
                    end
                end
                S_DIV: begin
                    quo_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_DONE;
                        res_d   = div_res;
                        cnt_d   = '0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule
